// File: rtl/clkdiv_meas_16.sv
// clkdiv_meas_16
//   Period and duty meter for a slow square wave, typically a divided clock.
//   The input is synchronised into the clkin domain. The meter counts clkin
//   cycles per input period (K) and per high phase. Each completed
//   measurement is reported with a one-cycle valid strobe.
//
// Ports
//   clkin     in   system clock, all logic on its rising edge
//   rst       in   synchronous active-high reset (wins over en)
//   en        in   measurement enable, low forces IDLE and clears flags
//   sig_in    in   asynchronous square wave to be measured
//   k_out     out  last measured period in clkin cycles
//   high_out  out  high-phase length belonging to that period
//   valid     out  one-cycle strobe, k_out/high_out just updated
//   locked    out  last two measured periods were equal
//   err       out  sticky: no rising edge within 2^N_BIT-1 cycles
module clkdiv_meas_16 #(
    parameter int N_BIT = 16
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [N_BIT-1:0] k_out,
    output logic [N_BIT-1:0] high_out,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    localparam logic [N_BIT-1:0] ONE = {{(N_BIT-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [N_BIT-1:0] per_q, per_d;
    logic [N_BIT-1:0] hi_q, hi_d;
    logic [N_BIT-1:0] hi_lat_q, hi_lat_d;
    logic [N_BIT-1:0] k_prev_q, k_prev_d;
    logic             have_prev_q, have_prev_d;
    logic [N_BIT-1:0] k_q, k_d;
    logic [N_BIT-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;

    logic rise, fall, per_full;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign per_full = (per_q == '1);

    // Synchroniser runs independently of en; only rst clears it.
    always_ff @(posedge clkin) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State register
    always_ff @(posedge clkin) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (rise) state_d = S_MEASURE;
                S_MEASURE: if (!rise && per_full) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next-values
    always_comb begin
        per_d       = per_q;
        hi_d        = hi_q;
        hi_lat_d    = hi_lat_q;
        k_prev_d    = k_prev_q;
        have_prev_d = have_prev_q;
        k_d         = k_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        err_d       = err_q;

        if (!en) begin
            per_d       = '0;
            hi_d        = '0;
            have_prev_d = 1'b0;
            locked_d    = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    have_prev_d = 1'b0;
                    locked_d    = 1'b0;
                    if (rise) begin
                        per_d = ONE;
                        hi_d  = ONE;
                    end else begin
                        per_d = '0;
                        hi_d  = '0;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        // A rise coinciding with per == all-ones is a legal
                        // capture, so it is tested before the overflow case.
                        k_d         = per_q;
                        high_d      = hi_lat_q;
                        valid_d     = 1'b1;
                        k_prev_d    = per_q;
                        have_prev_d = 1'b1;
                        locked_d    = have_prev_q && (per_q == k_prev_q);
                        per_d       = ONE;
                        hi_d        = ONE;
                    end else if (per_full) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        per_d    = '0;
                        hi_d     = '0;
                    end else begin
                        per_d = per_q + ONE;
                        if (s2_q && (hi_q != '1)) hi_d = hi_q + ONE;
                        if (fall) hi_lat_d = hi_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clkin) begin
        if (rst) begin
            per_q       <= '0;
            hi_q        <= '0;
            hi_lat_q    <= '0;
            k_prev_q    <= '0;
            have_prev_q <= 1'b0;
            k_q         <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            per_q       <= per_d;
            hi_q        <= hi_d;
            hi_lat_q    <= hi_lat_d;
            k_prev_q    <= k_prev_d;
            have_prev_q <= have_prev_d;
            k_q         <= k_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign k_out    = k_q;
    assign high_out = high_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign err      = err_q;

endmodule
